bp_me_l2_bank_steer: RTL and testbench
======================================

// Module: bp_me_l2_bank_steer
// PURPOSE
//  Multi-bank successor to the single-L2 unicore memory path. Accepts single-beat
//  memory commands and steers each one to one of num_banks_p bsg_cache-style bank
//  ports by block-address bits. Returns bank responses to the requester in command
//  order, tracked by an order FIFO of {bank, tag, wr}. Sits between cce_to_cache and
//  N L2 banks.
// PARAMETERS
//  num_banks_p      4   bank count; power of 2, >=2
//  paddr_width_p    40  physical address width
//  data_width_p     64  command/response data width; multiple of 8
//  block_offset_p   6   log2 L2 block bytes; bank bits start here
//  tag_width_p      8   requester tag, echoed on the response
//  order_els_p      8   order FIFO depth = max outstanding; power of 2, >=2
// PORTS
//  clk_i              in   1         clock
//  reset_n_i          in   1         async active-low reset
//  cmd_addr_i         in   paddr     command address
//  cmd_wr_i           in   1         1=store, 0=load
//  cmd_data_i         in   data      store data
//  cmd_mask_i         in   data/8    byte mask
//  cmd_tag_i          in   tag       requester tag
//  cmd_v_i            in   1         command valid
//  cmd_ready_and_o    out  1         command accepted when v&ready
//  bank_addr_o        out  N*paddr   per-bank address (cmd_addr_i fanned out)
//  bank_wr_o          out  N         per-bank write
//  bank_data_o        out  N*data    per-bank store data
//  bank_mask_o        out  N*data/8  per-bank byte mask
//  bank_v_o           out  N         per-bank packet valid
//  bank_ready_and_i   in   N         per-bank packet ready
//  bank_data_i        in   N*data    per-bank response data
//  bank_v_i           in   N         per-bank response valid
//  bank_yumi_o        out  N         per-bank response consume
//  resp_data_o        out  data      response data (loads; don't-care for stores)
//  resp_tag_o         out  tag       echoed tag
//  resp_wr_o          out  1         echoed wr
//  resp_v_o           out  1         response valid
//  resp_ready_and_i   in   1         response consumed when v&ready
//  outstanding_o      out  lg(els)+1 current order FIFO occupancy
// BEHAVIOUR
//  - Reset: reset_n_i low asynchronously clears FIFO pointers and count. While in
//    reset and after: cmd_ready_and_o=0 only if full; bank_v_o=0, bank_yumi_o=0,
//    resp_v_o=0, outstanding_o=0. Reset mid-transaction drops all outstanding
//    entries; the banks are reset on the same reset.
//  - sel = cmd_addr_i[block_offset_p +: lg(num_banks_p)].
//  - Command path is combinational, 0-cycle latency:
//    bank_v_o[b] = cmd_v_i & (sel==b) & ~full.
//    cmd_ready_and_o = bank_ready_and_i[sel] & ~full.
//    All bank_*_o data fields carry the cmd_* inputs unmodified.
//  - Push {sel, cmd_tag_i, cmd_wr_i} on cmd_v_i & cmd_ready_and_o.
//  - Full (count==order_els_p) blocks acceptance even when a pop happens in the
//    same cycle; no same-cycle bypass.
//  - Response path is combinational, 0-cycle latency. With head={hb,ht,hw}:
//    resp_v_o = ~empty & bank_v_i[hb]; resp_data_o = bank_data_i[hb];
//    resp_tag_o = ht; resp_wr_o = hw.
//    bank_yumi_o[hb] = resp_v_o & resp_ready_and_i; other yumis are 0. Pop on the
//    same condition.
//  - A non-head bank holding a valid response stalls, unconsumed, until it becomes
//    head, which preserves order.
//  - Simultaneous push & pop when not full: count unchanged; both pointers advance,
//    wrapping mod order_els_p.
//  - Empty: resp_v_o=0 regardless of bank_v_i. Any bank_v_i while empty is a
//    protocol error (assertion).
//  - Single beat per command; no multi-beat bursts.
// CONFIGURATION
//  BP_ME_L2_BANK_HASH_EN defined:
//    sel = addr[off +: lg] ^ addr[off+lg +: lg], where off=block_offset_p and
//    lg=lg(num_banks_p). Spreads power-of-2 strides across banks.
//  BP_ME_L2_BANK_HASH_EN undefined: plain bit-slice select as above.
//  All other behaviour is identical in both builds.
// TESTING (defaults N=4, els=8, no hash unless noted)
//  1. Load addr 0x0040 (sel=1), bank1 returns 0xDEAD after 3 cycles -> bank_v_o=4'b0010;
//     resp_data_o=0xDEAD, tag echoed, bank_yumi_o=4'b0010 on resp handshake.
//  2. Loads to 0x00C0 (b3) then 0x0000 (b0), b0 answers first -> resp waits for b3;
//     responses emerge in order b3 then b0; b0 not yumi'd until b3 consumed.
//  3. 8 loads with no bank responses -> outstanding_o=8, cmd_ready_and_o=0; on one pop
//     ready returns the following cycle, not the pop cycle.
//  4. bank_ready_and_i[2]=0, cmd to 0x0080 -> cmd_ready_and_o=0, no push; ready rises
//     -> accepted the same cycle.
//  5. Assert reset_n_i low with 5 outstanding -> outstanding_o=0, resp_v_o=0
//     immediately, without waiting for a clock edge.
//  6. HASH_EN: addrs 0x000, 0x100, 0x200, 0x300 -> sel 0, 1, 2, 3 (no hash: all sel=0).

Source files
------------

// File: rtl/bp_me_l2_bank_steer.sv
// Steers single-beat memory commands to one of num_banks_p L2 bank ports and returns
// bank responses in command order. Define BP_ME_L2_BANK_HASH_EN for XOR-folded bank select.
module bp_me_l2_bank_steer #(
  parameter int num_banks_p    = 4,
  parameter int paddr_width_p  = 40,
  parameter int data_width_p   = 64,
  parameter int block_offset_p = 6,
  parameter int tag_width_p    = 8,
  parameter int order_els_p    = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [paddr_width_p-1:0]              cmd_addr_i,
  input  logic                                  cmd_wr_i,
  input  logic [data_width_p-1:0]               cmd_data_i,
  input  logic [data_width_p/8-1:0]             cmd_mask_i,
  input  logic [tag_width_p-1:0]                cmd_tag_i,
  input  logic                                  cmd_v_i,
  output logic                                  cmd_ready_and_o,
  output logic [num_banks_p*paddr_width_p-1:0]  bank_addr_o,
  output logic [num_banks_p-1:0]                bank_wr_o,
  output logic [num_banks_p*data_width_p-1:0]   bank_data_o,
  output logic [num_banks_p*data_width_p/8-1:0] bank_mask_o,
  output logic [num_banks_p-1:0]                bank_v_o,
  input  logic [num_banks_p-1:0]                bank_ready_and_i,
  input  logic [num_banks_p*data_width_p-1:0]   bank_data_i,
  input  logic [num_banks_p-1:0]                bank_v_i,
  output logic [num_banks_p-1:0]                bank_yumi_o,
  output logic [data_width_p-1:0]               resp_data_o,
  output logic [tag_width_p-1:0]                resp_tag_o,
  output logic                                  resp_wr_o,
  output logic                                  resp_v_o,
  input  logic                                  resp_ready_and_i,
  output logic [$clog2(order_els_p):0]          outstanding_o
);

  localparam int lg_banks_lp  = $clog2(num_banks_p);
  localparam int ptr_width_lp = $clog2(order_els_p);
  localparam int cnt_width_lp = ptr_width_lp + 1;

  // Handshakes: a transfer happens on the rising edge where valid and ready are both
  // high. Command and response valids never depend on their own ready; bank yumi is
  // a consume strobe asserted only while the addressed bank presents valid.

  typedef struct packed {
    logic [lg_banks_lp-1:0] bank;
    logic [tag_width_p-1:0] tag;
    logic                   wr;
  } order_entry_t;

  order_entry_t            order_mem_q [order_els_p];
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;

  logic [lg_banks_lp-1:0]  sel;
  logic                    full, empty;
  logic                    push, pop;
  order_entry_t            head;
  order_entry_t            push_entry;
  logic [data_width_p-1:0] bank_data_arr [num_banks_p];

`ifdef BP_ME_L2_BANK_HASH_EN
  assign sel = cmd_addr_i[block_offset_p +: lg_banks_lp]
             ^ cmd_addr_i[block_offset_p+lg_banks_lp +: lg_banks_lp];
`else
  assign sel = cmd_addr_i[block_offset_p +: lg_banks_lp];
`endif

  assign full  = (count_q == cnt_width_lp'(order_els_p));
  assign empty = (count_q == '0);

  // Command path: pure fan-out, the selected bank's ready gates acceptance.
  assign bank_addr_o     = {num_banks_p{cmd_addr_i}};
  assign bank_wr_o       = {num_banks_p{cmd_wr_i}};
  assign bank_data_o     = {num_banks_p{cmd_data_i}};
  assign bank_mask_o     = {num_banks_p{cmd_mask_i}};
  assign cmd_ready_and_o = bank_ready_and_i[sel] & ~full;
  assign push            = cmd_v_i & cmd_ready_and_o;

  assign push_entry.bank = sel;
  assign push_entry.tag  = cmd_tag_i;
  assign push_entry.wr   = cmd_wr_i;

  for (genvar g = 0; g < num_banks_p; g++) begin : g_unpack
    assign bank_data_arr[g] = bank_data_i[g*data_width_p +: data_width_p];
  end

  // Only the bank at the head of the order FIFO may hand back a response.
  assign head        = order_mem_q[rd_ptr_q];
  assign resp_v_o    = ~empty & bank_v_i[head.bank];
  assign resp_data_o = bank_data_arr[head.bank];
  assign resp_tag_o  = head.tag;
  assign resp_wr_o   = head.wr;
  assign pop         = resp_v_o & resp_ready_and_i;

  assign outstanding_o = count_q;

  always_comb begin
    bank_v_o    = '0;
    bank_yumi_o = '0;
    for (int b = 0; b < num_banks_p; b++) begin
      bank_v_o[b]    = cmd_v_i & ~full & (sel == lg_banks_lp'(b));
      bank_yumi_o[b] = pop & (head.bank == lg_banks_lp'(b));
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries are cleared too so the head fields are never unknown while empty.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < order_els_p; i++) order_mem_q[i] <= '0;
    end else if (push) begin
      order_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  a_no_bank_resp_when_empty: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) empty |-> (bank_v_i == '0));

  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) full |-> !push);

endmodule

// File: tb/tb_bp_me_l2_bank_steer.sv
// Bench for bp_me_l2_bank_steer: vector table, hand-written ordering/full/reset
// sequences, and an in-order response scoreboard fed by a simple bank model.
module tb_bp_me_l2_bank_steer;

  localparam int N   = 4;
  localparam int AW  = 40;
  localparam int DW  = 64;
  localparam int MW  = DW/8;
  localparam int TW  = 8;
  localparam int ELS = 8;
  localparam int EW  = 2 + 1 + TW + DW;

  // clock / reset
  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [AW-1:0]   cmd_addr_i = '0;
  logic            cmd_wr_i = 1'b0;
  logic [DW-1:0]   cmd_data_i = '0;
  logic [MW-1:0]   cmd_mask_i = '0;
  logic [TW-1:0]   cmd_tag_i = '0;
  logic            cmd_v_i = 1'b0;
  logic            cmd_ready_and_o;
  logic [N*AW-1:0] bank_addr_o;
  logic [N-1:0]    bank_wr_o;
  logic [N*DW-1:0] bank_data_o;
  logic [N*MW-1:0] bank_mask_o;
  logic [N-1:0]    bank_v_o;
  logic [N-1:0]    bank_ready_and_i = '1;
  logic [N*DW-1:0] bank_data_i;
  logic [N-1:0]    bank_v_i;
  logic [N-1:0]    bank_yumi_o;
  logic [DW-1:0]   resp_data_o;
  logic [TW-1:0]   resp_tag_o;
  logic            resp_wr_o;
  logic            resp_v_o;
  logic            resp_ready_and_i = 1'b1;
  logic [3:0]      outstanding_o;

  bp_me_l2_bank_steer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wr_i(cmd_wr_i), .cmd_data_i(cmd_data_i),
    .cmd_mask_i(cmd_mask_i), .cmd_tag_i(cmd_tag_i), .cmd_v_i(cmd_v_i),
    .cmd_ready_and_o(cmd_ready_and_o),
    .bank_addr_o(bank_addr_o), .bank_wr_o(bank_wr_o), .bank_data_o(bank_data_o),
    .bank_mask_o(bank_mask_o), .bank_v_o(bank_v_o), .bank_ready_and_i(bank_ready_and_i),
    .bank_data_i(bank_data_i), .bank_v_i(bank_v_i), .bank_yumi_o(bank_yumi_o),
    .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o), .resp_wr_o(resp_wr_o),
    .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i),
    .outstanding_o(outstanding_o)
  );

  function automatic logic [1:0] ref_sel(input logic [AW-1:0] a);
`ifdef BP_ME_L2_BANK_HASH_EN
    return a[7:6] ^ a[9:8];
`else
    return a[7:6];
`endif
  endfunction

  function automatic logic [DW-1:0] resp_fn(input logic [1:0] b, input logic [AW-1:0] a);
    return {6'b0, b, a, 16'hDEAD};
  endfunction

  // counters: main sequence and scoreboard keep their own, merged at the end
  int n_checks = 0, n_pass = 0;
  int sb_checks = 0, sb_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic sb_chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    sb_checks++;
    if (act === exp) sb_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // scoreboard + bank model
  logic [EW-1:0] exp_q [$];
  logic [95:0]   bq [N][$];
  logic [N-1:0]  hold = '0;
  int            lat = 2;
  int            cyc = 0;

  initial begin : bank_model
    logic [EW-1:0] e;
    logic [95:0]   be;
    logic [N-1:0]  v;
    logic [N-1:0]  yexp;
    bank_v_i    = '0;
    bank_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        for (int b = 0; b < N; b++) bq[b].delete();
        exp_q.delete();
      end else begin
        cyc++;
        yexp = '0;
        if (resp_v_o && resp_ready_and_i) begin
          if (exp_q.size() == 0) begin
            sb_checks++;
            $display("FAIL resp_unexpected: got response tag 0x%0h with none outstanding", resp_tag_o);
          end else begin
            e = exp_q.pop_front();
            yexp = 4'(1) << e[EW-1 -: 2];
            sb_chk("resp_tag", resp_tag_o, e[DW +: TW]);
            sb_chk("resp_wr", resp_wr_o, e[DW+TW]);
            if (!e[DW+TW]) sb_chk("resp_data", resp_data_o, e[DW-1:0]);
          end
        end
        sb_chk("bank_yumi", bank_yumi_o, yexp);
        for (int b = 0; b < N; b++)
          if (bank_yumi_o[b] && bq[b].size() > 0) void'(bq[b].pop_front());
        if (cmd_v_i && cmd_ready_and_o)
          exp_q.push_back({ref_sel(cmd_addr_i), cmd_wr_i, cmd_tag_i,
                           cmd_wr_i ? 64'h0 : resp_fn(ref_sel(cmd_addr_i), cmd_addr_i)});
        for (int b = 0; b < N; b++)
          if (bank_v_o[b] && bank_ready_and_i[b])
            bq[b].push_back({32'(cyc + lat), resp_fn(2'(b), bank_addr_o[b*AW +: AW])});
      end
      @(posedge clk_i);
      #1;
      v = '0;
      for (int b = 0; b < N; b++) begin
        if (reset_n_i && !hold[b] && bq[b].size() > 0) begin
          be = bq[b][0];
          if (int'(be[95:64]) <= cyc) begin
            v[b] = 1'b1;
            bank_data_i[b*DW +: DW] = be[DW-1:0];
          end
        end
      end
      bank_v_i = v;
    end
  end

  // driver tasks
  task automatic issue(input logic [AW-1:0] a, input logic wr, input logic [TW-1:0] tag);
    @(posedge clk_i);
    #1;
    cmd_v_i    = 1'b1;
    cmd_addr_i = a;
    cmd_wr_i   = wr;
    cmd_tag_i  = tag;
    cmd_data_i = {$urandom, $urandom};
    cmd_mask_i = 8'($urandom_range(0, 255));
  endtask

  task automatic idle_cmd();
    @(posedge clk_i);
    #1;
    cmd_v_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk_i);
      #2;
      k++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_resp(input string name);
    int k;
    k = 0;
    @(negedge clk_i);
    while (!resp_v_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk({name, "_resp_v"}, resp_v_o, 1);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [TW-1:0] tag;
    int            sel_plain;
    int            sel_hash;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    int es;
    vecs[0] = '{40'h00_0000_0040, 1'b0, 8'h11, 1, 1};
    vecs[1] = '{40'h00_0000_00C0, 1'b0, 8'h22, 3, 3};
    vecs[2] = '{40'h00_0000_0000, 1'b1, 8'h33, 0, 0};
    vecs[3] = '{40'h00_0000_0080, 1'b0, 8'h44, 2, 2};
    vecs[4] = '{40'h00_0000_0100, 1'b0, 8'h45, 0, 1};
    vecs[5] = '{40'h00_0000_0200, 1'b1, 8'h46, 0, 2};
    vecs[6] = '{40'h00_0000_0300, 1'b0, 8'h47, 0, 3};
    vecs[7] = '{40'h00_0000_01C0, 1'b1, 8'h48, 3, 2};
    vecs[8] = '{40'h00_FFFF_FFC0, 1'b0, 8'h49, 3, 0};
    vecs[9] = '{40'hAB_CDEF_0240, 1'b0, 8'h4A, 1, 3};

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_bank_v", bank_v_o, 0);
    chk("rst_yumi", bank_yumi_o, 0);
    chk("rst_cmd_ready", cmd_ready_and_o, 1);
    #2 reset_n_i = 1'b1;

    // table vectors
    lat = 2;
    for (int i = 0; i < 10; i++) begin
`ifdef BP_ME_L2_BANK_HASH_EN
      es = vecs[i].sel_hash;
`else
      es = vecs[i].sel_plain;
`endif
      issue(vecs[i].addr, vecs[i].wr, vecs[i].tag);
      @(negedge clk_i);
      chk("tbl_bank_v", bank_v_o, 4'(1) << es);
      chk("tbl_ready", cmd_ready_and_o, 1);
      chk("tbl_addr", bank_addr_o[es*AW +: AW], vecs[i].addr);
      chk("tbl_data", bank_data_o[es*DW +: DW], cmd_data_i);
      chk("tbl_mask", bank_mask_o[es*MW +: MW], cmd_mask_i);
      chk("tbl_wr", bank_wr_o[es], vecs[i].wr);
      idle_cmd();
      drain("tbl");
    end

    // single load to bank 1, response three cycles later
    lat = 3;
    issue(40'h40, 1'b0, 8'h5A);
    @(negedge clk_i);
    chk("t1_bank_v", bank_v_o, 4'b0010);
    idle_cmd();
    wait_resp("t1");
    chk("t1_data_lo", resp_data_o[15:0], 16'hDEAD);
    chk("t1_tag", resp_tag_o, 8'h5A);
    chk("t1_yumi", bank_yumi_o, 4'b0010);
    drain("t1");

    // bank 0 answers before bank 3 but must wait behind it
    lat = 0;
    @(negedge clk_i);
    hold = 4'b1000;
    issue(40'hC0, 1'b0, 8'h01);
    issue(40'h00, 1'b0, 8'h02);
    idle_cmd();
    repeat (3) @(negedge clk_i);
    chk("t2_resp_v_stall", resp_v_o, 0);
    chk("t2_yumi_stall", bank_yumi_o, 0);
    chk("t2_outstanding", outstanding_o, 2);
    hold = '0;
    wait_resp("t2a");
    chk("t2_first_tag", resp_tag_o, 8'h01);
    chk("t2_first_yumi", bank_yumi_o, 4'b1000);
    @(negedge clk_i);
    chk("t2_second_tag", resp_tag_o, 8'h02);
    chk("t2_second_yumi", bank_yumi_o, 4'b0001);
    drain("t2");

    // fill the order FIFO, then free one slot
    @(negedge clk_i);
    hold = 4'b1111;
    for (int i = 0; i < ELS; i++) begin
      issue(40'(i * 64), 1'b0, 8'(8'h30 + i));
      @(negedge clk_i);
      chk("t3_fill_ready", cmd_ready_and_o, 1);
    end
    issue(40'h0, 1'b0, 8'h39);
    @(negedge clk_i);
    chk("t3_full_count", outstanding_o, 8);
    chk("t3_full_ready", cmd_ready_and_o, 0);
    chk("t3_full_bank_v", bank_v_o, 0);
    @(negedge clk_i);
    hold = 4'b1110;
    @(negedge clk_i);
    chk("t3_pop_resp_v", resp_v_o, 1);
    chk("t3_pop_ready", cmd_ready_and_o, 0);
    chk("t3_pop_count", outstanding_o, 8);
    @(negedge clk_i);
    chk("t3_after_count", outstanding_o, 7);
    chk("t3_after_ready", cmd_ready_and_o, 1);
    idle_cmd();
    @(negedge clk_i);
    chk("t3_refill_count", outstanding_o, 8);
    hold = '0;
    drain("t3");

    // selected bank not ready
    lat = 2;
    issue(40'h80, 1'b0, 8'h44);
    bank_ready_and_i = 4'b1011;
    @(negedge clk_i);
    chk("t4_ready_low", cmd_ready_and_o, 0);
    chk("t4_bank_v", bank_v_o, 4'b0100);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("t4_no_push", outstanding_o, 0);
    @(posedge clk_i);
    #1;
    bank_ready_and_i = 4'b1111;
    @(negedge clk_i);
    chk("t4_ready_high", cmd_ready_and_o, 1);
    idle_cmd();
    @(negedge clk_i);
    chk("t4_pushed", outstanding_o, 1);
    drain("t4");

    // asynchronous reset with five outstanding
    @(negedge clk_i);
    hold = 4'b1111;
    for (int i = 0; i < 5; i++) issue(40'(i * 64), 1'b0, 8'(8'h60 + i));
    idle_cmd();
    resp_ready_and_i = 1'b0;
    @(negedge clk_i);
    hold = 4'b1110;
    repeat (2) @(negedge clk_i);
    chk("t5_pre_resp_v", resp_v_o, 1);
    chk("t5_pre_count", outstanding_o, 5);
    #2 reset_n_i = 1'b0;
    #1;
    chk("t5_async_count", outstanding_o, 0);
    chk("t5_async_resp_v", resp_v_o, 0);
    chk("t5_async_yumi", bank_yumi_o, 0);
    @(posedge clk_i);
    #1;
    resp_ready_and_i = 1'b1;
    @(negedge clk_i);
    chk("t5_in_reset_ready", cmd_ready_and_o, 1);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    #2;
    hold = '0;
    reset_n_i = 1'b1;
    issue(40'hC0, 1'b0, 8'h77);
    idle_cmd();
    drain("t5_post");

    repeat (3) @(negedge clk_i);
    n_checks += sb_checks;
    n_pass   += sb_pass;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: no finish after 500000 ns");
    $fatal(1, "timeout");
  end

endmodule
